// File: rtl/ram_copy_engine.sv
// Memory-side block copy / block fill sequencer for a two-port RAM.
// Port 0 only reads, port 1 only writes, so one word moves per clock.
module ram_copy_engine #(
    parameter int mem_width  = 12,
    parameter int addr_width = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic [addr_width-1:0]     src,
    input  logic [addr_width-1:0]     dst,
    input  logic [addr_width:0]       len,
    input  logic [mem_width-1:0]      pattern,
    output logic [2*addr_width-1:0]   ram_address,
    output logic [2*mem_width-1:0]    ram_datain,
    output logic [1:0]                ram_mem_write,
    input  logic [2*mem_width-1:0]    ram_dataout,
    output logic                      busy,
    output logic                      done,
    output logic [addr_width:0]       words_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [addr_width:0] LAT_M1 = (addr_width+1)'(RD_LAT - 1);

    state_t                  r_state, w_next;
    logic                    r_mode;
    logic [addr_width-1:0]   r_src, r_dst;
    logic [addr_width:0]     r_len, r_cnt, r_words;
    logic [mem_width-1:0]    r_pattern;
    logic [RD_LAT-1:0]       r_vld;

    logic                    w_rd, w_wr, w_wr_copy, w_wr_fill;
    logic [mem_width-1:0]    w_wdata;
    logic [addr_width-1:0]   w_rd_addr, w_wr_addr;
    logic                    w_unused;

    // Upper read half belongs to the write port and is never consumed.
    assign w_unused = ^ram_dataout[2*mem_width-1:mem_width];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (r_cnt == r_len - 1'b1) w_next = r_mode ? S_DONE : S_DRAIN;
            S_DRAIN: if (r_cnt == LAT_M1) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_words   <= '0;
            r_pattern <= '0;
            r_vld     <= '0;
        end else begin
            r_state <= w_next;
            r_vld   <= RD_LAT'({r_vld, w_rd});
            if (w_wr) r_words <= r_words + 1'b1;
            case (r_state)
                S_IDLE: if (start) begin
                    r_mode    <= mode;
                    r_src     <= src;
                    r_dst     <= dst;
                    r_len     <= len;
                    r_pattern <= pattern;
                    r_cnt     <= '0;
                    r_words   <= '0;
                end
                S_RUN:   r_cnt <= (w_next == S_RUN) ? r_cnt + 1'b1 : '0;
                S_DRAIN: r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Writes retire strictly in order, so the write offset is the write count.
    assign w_rd      = (r_state == S_RUN) && !r_mode;
    assign w_wr_fill = (r_state == S_RUN) && r_mode;
    assign w_wr_copy = r_vld[RD_LAT-1];
    assign w_wr      = w_wr_fill || w_wr_copy;
    assign w_rd_addr = w_rd ? r_src + r_cnt[addr_width-1:0] : '0;
    assign w_wr_addr = w_wr ? r_dst + r_words[addr_width-1:0] : '0;

    always_comb begin
        w_wdata = '0;
        if (w_wr_fill)      w_wdata = r_pattern;
        else if (w_wr_copy) w_wdata = ram_dataout[mem_width-1:0];
    end

    assign ram_address   = {w_wr_addr, w_rd_addr};
    assign ram_datain    = {w_wdata, {mem_width{1'b0}}};
    assign ram_mem_write = {w_wr, 1'b0};
    assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done          = (r_state == S_DONE);
    assign words_done    = r_words;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench: two engines (RD_LAT 1 and 3), each on its own behavioural RAM.
module tb_ram_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0, mode = 1'b0;
    logic [11:0] src = '0, dst = '0, pattern = '0;
    logic [12:0] len = '0;

    logic [23:0] a1_addr, a1_din, a1_dout, a3_addr, a3_din, a3_dout;
    logic [1:0]  a1_we, a3_we;
    logic        busy1, done1, busy3, done3;
    logic [12:0] wd1, wd3;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    ram_copy_engine #(.mem_width(12), .addr_width(12), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .mode(mode), .src(src), .dst(dst),
        .len(len), .pattern(pattern), .ram_address(a1_addr), .ram_datain(a1_din),
        .ram_mem_write(a1_we), .ram_dataout(a1_dout), .busy(busy1), .done(done1),
        .words_done(wd1));

    ram_copy_engine #(.mem_width(12), .addr_width(12), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .start(start3), .mode(mode), .src(src), .dst(dst),
        .len(len), .pattern(pattern), .ram_address(a3_addr), .ram_datain(a3_din),
        .ram_mem_write(a3_we), .ram_dataout(a3_dout), .busy(busy3), .done(done3),
        .words_done(wd3));

    // Behavioural RAMs: read-before-write, registered read pipeline of RD_LAT stages.
    logic [11:0] mem1 [4096];
    logic [11:0] mem3 [4096];
    logic [11:0] p1, p3_0, p3_1, p3_2;
    logic        pl_en1 = 1'b0, pl_en3 = 1'b0;
    logic [11:0] pl_a = '0, pl_d = '0;

    always @(posedge clk) begin
        if (a1_we[1]) mem1[a1_addr[23:12]] <= a1_din[23:12];
        if (pl_en1)   mem1[pl_a] <= pl_d;
        p1 <= mem1[a1_addr[11:0]];
    end
    always @(posedge clk) begin
        if (a3_we[1]) mem3[a3_addr[23:12]] <= a3_din[23:12];
        if (pl_en3)   mem3[pl_a] <= pl_d;
        p3_0 <= mem3[a3_addr[11:0]];
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign a1_dout = {12'h000, p1};
    assign a3_dout = {12'h000, p3_2};

    // Per-cycle monitor of the selected engine; cycle 1 is the one after the start edge.
    logic        sel = 1'b0, mon_on = 1'b0;
    int          cyc, n_done, n_we0, done_cyc;
    int          wr_cyc[$];
    int          wr_addr[$];
    logic [11:0] rd_a [32];
    logic [23:0] m_addr;
    logic [1:0]  m_we;
    logic        m_done;

    assign m_addr = sel ? a3_addr : a1_addr;
    assign m_we   = sel ? a3_we   : a1_we;
    assign m_done = sel ? done3   : done1;

    always @(negedge clk) if (mon_on) begin
        if (m_we[1]) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(m_addr[23:12]));
        end
        if (m_we[0]) n_we0++;
        if (m_done) begin n_done++; done_cyc = cyc; end
        if (cyc < 32) rd_a[cyc] = m_addr[11:0];
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int wc(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction
    function automatic int wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : -1;
    endfunction

    task automatic preload(input logic which, input logic [11:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        pl_a = a; pl_d = d; pl_en1 = !which; pl_en3 = which;
        @(posedge clk); #1;
        pl_en1 = 1'b0; pl_en3 = 1'b0;
    endtask

    // Issue one command; optionally pulse start again on cycle 'poke'.
    task automatic run_cmd(input logic s, input logic m, input logic [11:0] sa,
                           input logic [11:0] da, input logic [12:0] ln,
                           input logic [11:0] pat, input int poke);
        @(posedge clk); #1;
        sel = s; mode = m; src = sa; dst = da; len = ln; pattern = pat;
        start1 = !s; start3 = s;
        wr_cyc.delete(); wr_addr.delete();
        n_done = 0; n_we0 = 0; done_cyc = -1; cyc = 0; mon_on = 1'b1;
        for (int i = 1; i <= int'(ln) + 10; i++) begin
            @(posedge clk); #1;
            start1 = 1'b0; start3 = 1'b0;
            if (i == poke) begin start1 = !s; start3 = s; end
        end
        mon_on = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_we", a1_we, 0);
        chk("rst_addr", a1_addr, 0);
        chk("rst_data", a1_din, 0);
        chk("rst_wd", wd1, 0);
        #20 rst_n = 1'b1;

        // Copy 4 words, RD_LAT=1
        for (int i = 0; i < 4; i++) preload(0, 12'(i), 12'(12'h111 * (i + 1)));
        for (int i = 0; i < 4; i++) preload(0, 12'(100 + i), 12'h000);
        run_cmd(0, 0, 12'd0, 12'd100, 13'd4, 12'h000, 0);
        chk("cp_nwr", wr_cyc.size(), 4);
        chk("cp_wc0", wc(0), 2);
        chk("cp_wc3", wc(3), 5);
        chk("cp_wa0", wa(0), 100);
        chk("cp_wa3", wa(3), 103);
        chk("cp_done_cyc", done_cyc, 6);
        chk("cp_ndone", n_done, 1);
        chk("cp_wd", wd1, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cp_mem%0d", i), mem1[100 + i], 12'h111 * (i + 1));

        // Fill 3 words
        preload(0, 12'd13, 12'h123);
        run_cmd(0, 1, 12'd0, 12'd10, 13'd3, 12'hABC, 0);
        for (int i = 0; i < 3; i++) chk($sformatf("fl_mem%0d", 10 + i), mem1[10 + i], 12'hABC);
        chk("fl_mem13", mem1[13], 12'h123);
        chk("fl_done_cyc", done_cyc, 4);
        chk("fl_we0", n_we0, 0);
        chk("fl_wd", wd1, 3);

        // Address wrap
        preload(0, 12'd4094, 12'h5A5);
        preload(0, 12'd4095, 12'h0F0);
        preload(0, 12'd0, 12'h777);
        run_cmd(0, 0, 12'd4094, 12'd4095, 13'd2, 12'h000, 0);
        chk("wr_rd1", rd_a[1], 4094);
        chk("wr_rd2", rd_a[2], 4095);
        chk("wr_wa0", wa(0), 4095);
        chk("wr_wa1", wa(1), 0);
        chk("wr_m4095", mem1[4095], 12'h5A5);
        chk("wr_m0", mem1[0], 12'h0F0);

        // len=0
        run_cmd(0, 0, 12'd0, 12'd500, 13'd0, 12'h000, 0);
        chk("l0_done_cyc", done_cyc, 1);
        chk("l0_nwr", wr_cyc.size(), 0);
        chk("l0_ndone", n_done, 1);
        chk("l0_wd", wd1, 0);

        // Start during RUN is ignored
        run_cmd(0, 1, 12'd0, 12'd700, 13'd8, 12'h3C3, 3);
        chk("ig_nwr", wr_cyc.size(), 8);
        chk("ig_ndone", n_done, 1);
        chk("ig_done_cyc", done_cyc, 9);
        chk("ig_wd", wd1, 8);

        // Reset mid-copy
        for (int i = 0; i < 10; i++) preload(0, 12'(20 + i), 12'(12'h300 + i));
        for (int i = 0; i < 10; i++) preload(0, 12'(200 + i), 12'(12'hE00 + i));
        @(posedge clk); #1;
        sel = 0; mode = 0; src = 12'd20; dst = 12'd200; len = 13'd10; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("rs_pre_we", a1_we[1], 1);
        rst_n = 1'b0;
        #1;
        chk("rs_we", a1_we, 0);
        chk("rs_busy", busy1, 0);
        chk("rs_done", done1, 0);
        #20 rst_n = 1'b1;
        chk("rs_m200", mem1[200], 12'h300);
        for (int i = 3; i < 10; i++)
            chk($sformatf("rs_m%0d", 200 + i), mem1[200 + i], 12'hE00 + i);
        run_cmd(0, 1, 12'd0, 12'd300, 13'd2, 12'h5C5, 0);
        chk("rs_new_done_cyc", done_cyc, 3);
        chk("rs_new_m300", mem1[300], 12'h5C5);
        chk("rs_new_m301", mem1[301], 12'h5C5);
        chk("rs_new_wd", wd1, 2);

        // RD_LAT=3 copy
        for (int i = 0; i < 5; i++) preload(1, 12'(50 + i), 12'(12'h700 + i * 3));
        run_cmd(1, 0, 12'd50, 12'd60, 13'd5, 12'h000, 0);
        chk("l3_nwr", wr_cyc.size(), 5);
        chk("l3_wc0", wc(0), 4);
        chk("l3_wc4", wc(4), 8);
        chk("l3_done_cyc", done_cyc, 9);
        chk("l3_wd", wd3, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("l3_mem%0d", 60 + i), mem3[60 + i], 12'h700 + i * 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
